// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//
// Pipeline hazard controller for the 5-stage MIPS core. Detects load-use
// hazards and HI/LO hazards against the multi-cycle multiply/divide unit
// (MDU), and turns them into stall controls. It also turns taken branches
// and jumps resolved in ID into an IF/ID flush. The MDU occupancy is tracked
// with a 4-bit latency counter and a small RUN/BUSY/HWAIT state machine.
// Saturating stall and flush counters support performance analysis.
//
// Parameters:
//   MDU_LATENCY  cycles the MDU occupies HI/LO after a mult/div leaves ID (1..15)
//   CNT_WIDTH    width of the performance counters
//
// Ports:
//   CLOCK              in   system clock, rising edge
//   RESET              in   synchronous, active-high reset
//   ID_Rs_IN[4:0]      in   rs field of the instruction in ID
//   ID_Rt_IN[4:0]      in   rt field of the instruction in ID
//   ID_UsesRt_IN       in   ID instruction reads rt as a source
//   IDEX_MemRead_IN    in   instruction in EX is a load
//   IDEX_Rt_IN[4:0]    in   destination register of the load in EX
//   ID_BranchTaken_IN  in   branch in ID resolved taken
//   ID_Jump_IN         in   j/jal/jr in ID
//   ID_MDUStart_IN     in   mult/multu/div/divu in ID
//   ID_ReadsHILO_IN    in   mfhi/mflo in ID
//   PCWrite_OUT        out  PC update enable
//   IFID_STALL_OUT     out  hold the IF/ID register
//   IFID_FLUSH_OUT     out  zero the IF/ID register
//   IDEX_FLUSH_OUT     out  insert a bubble into ID/EX
//   MDUBusy_OUT        out  MDU still occupies HI/LO (registered)
//   StallCount_OUT     out  saturating count of stalled cycles
//   FlushCount_OUT     out  saturating count of IF/ID flush cycles
// ---------------------------------------------------------------------------
module hazard_controller #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic [4:0]           ID_Rs_IN,
  input  logic [4:0]           ID_Rt_IN,
  input  logic                 ID_UsesRt_IN,
  input  logic                 IDEX_MemRead_IN,
  input  logic [4:0]           IDEX_Rt_IN,
  input  logic                 ID_BranchTaken_IN,
  input  logic                 ID_Jump_IN,
  input  logic                 ID_MDUStart_IN,
  input  logic                 ID_ReadsHILO_IN,
  output logic                 PCWrite_OUT,
  output logic                 IFID_STALL_OUT,
  output logic                 IFID_FLUSH_OUT,
  output logic                 IDEX_FLUSH_OUT,
  output logic                 MDUBusy_OUT,
  output logic [CNT_WIDTH-1:0] StallCount_OUT,
  output logic [CNT_WIDTH-1:0] FlushCount_OUT
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    BUSY  = 2'd1,
    HWAIT = 2'd2
  } mduState_t;

  mduState_t            state_q, state_d;
  logic [3:0]           mduCount_q, mduCount_d;
  logic [CNT_WIDTH-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_WIDTH-1:0] flushCnt_q, flushCnt_d;

  logic loadUse;
  logic hiloHazard;
  logic stall;
  logic flush;
  logic mduAccept;

  // Hazard detection. A load into $0 never produces a real value, so it can
  // never create a dependence. The HI/LO hazard also catches a second mult/div
  // while the first is still running, since both would fight over HI/LO.
  always_comb begin
    loadUse    = IDEX_MemRead_IN && (IDEX_Rt_IN != 5'd0) &&
                 ((IDEX_Rt_IN == ID_Rs_IN) ||
                  (ID_UsesRt_IN && (IDEX_Rt_IN == ID_Rt_IN)));
    hiloHazard = (mduCount_q != 4'd0) && (ID_ReadsHILO_IN || ID_MDUStart_IN);
    stall      = loadUse || hiloHazard;
    flush      = !stall && (ID_BranchTaken_IN || ID_Jump_IN);
    mduAccept  = ID_MDUStart_IN && !stall;
  end

  // Pipeline control outputs. A stall masks a branch/jump because the branch
  // is simply re-presented in ID next cycle. During reset the pipeline is
  // frozen with every control deasserted, including the PC write.
  always_comb begin
    PCWrite_OUT    = 1'b0;
    IFID_STALL_OUT = 1'b0;
    IFID_FLUSH_OUT = 1'b0;
    IDEX_FLUSH_OUT = 1'b0;
    if (!RESET) begin
      if (stall) begin
        IFID_STALL_OUT = 1'b1;
        IDEX_FLUSH_OUT = 1'b1;
      end else if (flush) begin
        PCWrite_OUT    = 1'b1;
        IFID_FLUSH_OUT = 1'b1;
      end else begin
        PCWrite_OUT    = 1'b1;
      end
    end
  end

  // MDU latency counter and FSM next state. The counter is loaded only when the
  // mult/div actually leaves ID; a start held up by any stall just lets the
  // running count continue to drain. The FSM follows the counter: RUN when it
  // will be empty, HWAIT while a HI/LO consumer is being held off, else BUSY.
  always_comb begin
    mduCount_d = mduCount_q;
    state_d    = state_q;
    if (mduAccept) begin
      mduCount_d = 4'(MDU_LATENCY);
    end else if (mduCount_q != 4'd0) begin
      mduCount_d = mduCount_q - 4'd1;
    end

    case (state_q)
      RUN: begin
        if (mduAccept) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mduCount_d == 4'd0) begin
          state_d = RUN;
        end else if (hiloHazard) begin
          state_d = HWAIT;
        end
      end
      HWAIT: begin
        if (mduCount_d == 4'd0) begin
          state_d = RUN;
        end else if (!hiloHazard) begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Performance counters stop at all-ones rather than wrapping, so a long run
  // reads as "at least this many" instead of a misleading small number.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (stall && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_WIDTH'(1);
    end
    if (flush && (flushCnt_q != '1)) begin
      flushCnt_d = flushCnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers. Reset abandons any MDU operation in flight.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= RUN;
      mduCount_q <= 4'd0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mduCount_q <= mduCount_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign MDUBusy_OUT    = (state_q != RUN);
  assign StallCount_OUT = stallCnt_q;
  assign FlushCount_OUT = flushCnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
//
// Scoreboard bench for hazard_controller. The driver applies one input
// vector per cycle, computes the expected response from a cycle-level model
// of the pipeline rules (remaining MDU cycles, stall/flush totals) and queues
// it; a monitor pops one entry per cycle on the falling edge and compares.
// Counters are built narrow so saturation is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

  localparam int LAT     = 4;
  localparam int CW      = 5;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic [4:0]    ID_Rs_IN = '0;
  logic [4:0]    ID_Rt_IN = '0;
  logic          ID_UsesRt_IN = 1'b0;
  logic          IDEX_MemRead_IN = 1'b0;
  logic [4:0]    IDEX_Rt_IN = '0;
  logic          ID_BranchTaken_IN = 1'b0;
  logic          ID_Jump_IN = 1'b0;
  logic          ID_MDUStart_IN = 1'b0;
  logic          ID_ReadsHILO_IN = 1'b0;
  logic          PCWrite_OUT;
  logic          IFID_STALL_OUT;
  logic          IFID_FLUSH_OUT;
  logic          IDEX_FLUSH_OUT;
  logic          MDUBusy_OUT;
  logic [CW-1:0] StallCount_OUT;
  logic [CW-1:0] FlushCount_OUT;

  hazard_controller #(
    .MDU_LATENCY(LAT),
    .CNT_WIDTH  (CW)
  ) dut (
    .CLOCK            (CLOCK),
    .RESET            (RESET),
    .ID_Rs_IN         (ID_Rs_IN),
    .ID_Rt_IN         (ID_Rt_IN),
    .ID_UsesRt_IN     (ID_UsesRt_IN),
    .IDEX_MemRead_IN  (IDEX_MemRead_IN),
    .IDEX_Rt_IN       (IDEX_Rt_IN),
    .ID_BranchTaken_IN(ID_BranchTaken_IN),
    .ID_Jump_IN       (ID_Jump_IN),
    .ID_MDUStart_IN   (ID_MDUStart_IN),
    .ID_ReadsHILO_IN  (ID_ReadsHILO_IN),
    .PCWrite_OUT      (PCWrite_OUT),
    .IFID_STALL_OUT   (IFID_STALL_OUT),
    .IFID_FLUSH_OUT   (IFID_FLUSH_OUT),
    .IDEX_FLUSH_OUT   (IDEX_FLUSH_OUT),
    .MDUBusy_OUT      (MDUBusy_OUT),
    .StallCount_OUT   (StallCount_OUT),
    .FlushCount_OUT   (FlushCount_OUT)
  );

  always #5 CLOCK = ~CLOCK;

  // ctrl packs {PCWrite, IFID_STALL, IFID_FLUSH, IDEX_FLUSH}
  typedef struct packed {
    logic [3:0]    ctrl;
    logic          busy;
    logic [CW-1:0] stallCnt;
    logic [CW-1:0] flushCnt;
  } expect_t;

  expect_t sbQ[$];
  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state: cycles of MDU occupancy left and event totals.
  int mduRemaining = 0;
  int modelStalls  = 0;
  int modelFlushes = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, queue the response
  // the pipeline rules demand for this cycle, then advance the model across
  // the coming edge.
  task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic usesRt, input logic memRead, input logic [4:0] exRt,
                               input logic br, input logic jmp, input logic start,
                               input logic hilo);
    expect_t e;
    logic    lu, hh, st, fl;
    @(posedge CLOCK);
    #1;
    RESET             = rst;
    ID_Rs_IN          = rs;
    ID_Rt_IN          = rt;
    ID_UsesRt_IN      = usesRt;
    IDEX_MemRead_IN   = memRead;
    IDEX_Rt_IN        = exRt;
    ID_BranchTaken_IN = br;
    ID_Jump_IN        = jmp;
    ID_MDUStart_IN    = start;
    ID_ReadsHILO_IN   = hilo;

    lu = memRead && (exRt != 5'd0) && ((exRt == rs) || (usesRt && (exRt == rt)));
    hh = (mduRemaining > 0) && (hilo || start);
    st = lu || hh;
    fl = !st && (br || jmp);

    if (rst)     e.ctrl = 4'b0000;
    else if (st) e.ctrl = 4'b0101;
    else if (fl) e.ctrl = 4'b1010;
    else         e.ctrl = 4'b1000;
    e.busy     = (mduRemaining > 0);
    e.stallCnt = CW'(modelStalls);
    e.flushCnt = CW'(modelFlushes);
    sbQ.push_back(e);

    if (rst) begin
      mduRemaining = 0;
      modelStalls  = 0;
      modelFlushes = 0;
    end else begin
      if (start && !st)          mduRemaining = LAT;
      else if (mduRemaining > 0) mduRemaining = mduRemaining - 1;
      if (st) modelStalls  = (modelStalls  < CNT_MAX) ? modelStalls  + 1 : CNT_MAX;
      if (fl) modelFlushes = (modelFlushes < CNT_MAX) ? modelFlushes + 1 : CNT_MAX;
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resetCycle();
    applyStimulus(1'b1, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    expect_t e;
    forever begin
      @(negedge CLOCK);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("ctrl", int'({PCWrite_OUT, IFID_STALL_OUT, IFID_FLUSH_OUT, IDEX_FLUSH_OUT}),
                    int'(e.ctrl));
        checkOutput("mduBusy", int'(MDUBusy_OUT), int'(e.busy));
        checkOutput("stallCount", int'(StallCount_OUT), int'(e.stallCnt));
        checkOutput("flushCount", int'(FlushCount_OUT), int'(e.flushCnt));
      end
    end
  end

  initial begin
    // Reset held two cycles with inputs toggling, then idle release.
    resetCycle();
    resetCycle();
    idleCycle();
    checkOutput("resetStallCnt", int'(StallCount_OUT), 0);

    // Load-use on rs: exactly one stall.
    applyStimulus(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("luStallCount", int'(StallCount_OUT), 1);
    // $0 never hazards; rt match ignored when rt is not a source.
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("luNoFalseStall", int'(StallCount_OUT), 2);

    // Branch flush, then branch masked by a load-use stall.
    resetCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("branchFlushCount", int'(FlushCount_OUT), 1);
    applyStimulus(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("maskedFlushCount", int'(FlushCount_OUT), 1);
    checkOutput("maskedStallCount", int'(StallCount_OUT), 1);

    // mult at t, mfhi from t+1: stalls t+1..t+4, accepted at t+5.
    resetCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < LAT + 1; i++)
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idleCycle();
    checkOutput("mduStallCount", int'(StallCount_OUT), LAT);

    // Back-to-back mults: second waits 4 cycles then occupies the MDU again.
    resetCycle();
    for (int i = 0; i < LAT + 2; i++)
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < LAT + 1; i++) idleCycle();
    checkOutput("b2bStallCount", int'(StallCount_OUT), LAT);

    // Reset pulsed while a reader waits on HI/LO.
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("hwaitResetBusy", int'(MDUBusy_OUT), 0);

    // Saturation of both counters.
    resetCycle();
    for (int i = 0; i < CNT_MAX + 3; i++)
      applyStimulus(1'b0, 5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < CNT_MAX + 3; i++)
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idleCycle();
    checkOutput("stallSaturate", int'(StallCount_OUT), CNT_MAX);
    checkOutput("flushSaturate", int'(FlushCount_OUT), CNT_MAX);

    // Randomized traffic with small register numbers so matches are common.
    resetCycle();
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 39) == 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom_range(0, 2) == 0),
                    5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0));
    end
    idleCycle();

    @(negedge CLOCK);
    #1;
    checkOutput("scoreboardDrained", sbQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
